// File: rtl/spram_banked_if.sv
// rtl/spram_banked_if.sv - access bus for spram_banked; SPRAM_MASK_EN adds the nibble mask
interface spram_banked_if #(
    parameter int ADDR_W = 16
);
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [15:0]       in;
`ifdef SPRAM_MASK_EN
    logic [3:0]        mask;
`endif
    logic [15:0]       out;
    logic              ready;

`ifdef SPRAM_MASK_EN
    modport master (output load, address, in, mask, input out, ready);
    modport slave  (input load, address, in, mask, output out, ready);
`else
    modport master (output load, address, in, input out, ready);
    modport slave  (input load, address, in, output out, ready);
`endif
endinterface

// File: rtl/spram_banked.sv
// rtl/spram_banked.sv - 1-4 bank SPRAM main memory with post-reset clear; SPRAM_MASK_EN enables nibble writes
module spram_banked #(
    parameter int          BANKS        = 4,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] CLEAR_VALUE  = 16'h0000
) (
    input logic           clock,
    input logic           reset,
    spram_banked_if.slave bus
);
    localparam int ADDR_W   = (BANKS <= 1) ? 14 : $clog2(BANKS * 16384);
    localparam int OFFS_MAX = 16383;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    if (BANKS < 1 || BANKS > 4) begin : g_bad_banks
        $error("spram_banked: BANKS must be 1..4");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("spram_banked: READ_LATENCY must be 1 or 2");
    end

    logic [1:0]  state;
    logic [13:0] count;
    logic        ready;
    logic        clearing;

    // Narrow addresses are zero-extended so bank field and offset sit at fixed bit positions.
    logic [15:0] addr16;
    logic [1:0]  sel_in;
    logic [13:0] offs;
    logic        acc_wr;
    logic        acc_rd;
    logic [3:0]  mask_in;

    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [15:0] bank_rdata [4];

    logic        rd_v1;
    logic [1:0]  sel1;
    logic [15:0] rd_mux;
    logic        done;
    logic [15:0] done_data;
    logic [15:0] out_q;

    assign addr16   = 16'(bus.address[ADDR_W-1:0]);
    assign sel_in   = addr16[15:14];
    assign offs     = addr16[13:0];
    assign ready    = (state == S_READY);
    assign clearing = (state == S_CLEAR);
    assign acc_wr   = ready & bus.load;
    assign acc_rd   = ready & ~bus.load;

`ifdef SPRAM_MASK_EN
    assign mask_in = bus.mask;
`else
    assign mask_in = 4'hF;
`endif

    // While clearing, every bank sees the sweep counter and a full-width write of CLEAR_VALUE.
    assign mem_addr  = clearing ? count       : offs;
    assign mem_wdata = clearing ? CLEAR_VALUE : bus.in;
    assign mem_wmask = clearing ? 4'hF        : mask_in;

    // Post-reset sequencing: sweep all offsets, let the read pipeline settle, then open for access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_CLEAR;
            count <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (count == 14'(OFFS_MAX)) begin
                        state <= S_DRAIN;
                        count <= '0;
                    end else begin
                        count <= count + 14'd1;
                    end
                end
                S_DRAIN: begin
                    if (count == 14'(READ_LATENCY - 1)) begin
                        state <= S_READY;
                        count <= '0;
                    end else begin
                        count <= count + 14'd1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        if (b < BANKS) begin : g_used
            logic [15:0] mem [16384];
            logic [15:0] rdata;
            logic        wr_en;

            assign wr_en = clearing | (acc_wr & (sel_in == 2'(b)));

            // SPRAM equivalent: nibble-masked write and a registered read of the same offset.
            always_ff @(posedge clock) begin
                if (wr_en) begin
                    for (int k = 0; k < 4; k++) begin
                        if (mem_wmask[k]) begin
                            mem[mem_addr][4*k +: 4] <= mem_wdata[4*k +: 4];
                        end
                    end
                end
                rdata <= mem[mem_addr];
            end

            assign bank_rdata[b] = rdata;
        end else begin : g_absent
            // Missing banks read as zero, which covers the out-of-range field when BANKS=3.
            assign bank_rdata[b] = 16'h0000;
        end
    end

    assign rd_mux = bank_rdata[sel1];

    // Bank select travels alongside the SPRAM output register so the mux picks the right bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v1 <= 1'b0;
            sel1  <= '0;
        end else begin
            rd_v1 <= acc_rd;
            sel1  <= sel_in;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic        rd_v2;
        logic [15:0] data2;

        // Extra register stage between the bank mux and out.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_v2 <= 1'b0;
                data2 <= '0;
            end else begin
                rd_v2 <= rd_v1;
                data2 <= rd_mux;
            end
        end

        assign done      = rd_v2;
        assign done_data = data2;
    end else begin : g_lat1
        assign done      = rd_v1;
        assign done_data = rd_mux;
    end

    // out only moves when a read completes; writes and not-ready cycles hold it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (done) begin
            out_q <= done_data;
        end
    end

    assign bus.out   = out_q;
    assign bus.ready = ready;
endmodule
